// File: rtl/hps_rx_slot_ctrl_pkg.sv
// hps_rx_slot_pkg: shared state encoding, header codes and CSR bit positions
package hps_rx_slot_pkg;
    typedef enum logic [3:0] {
        IDLE, RX_POLL, RX_STAT, RX_RD, RX_WAIT, WAIT_SLOT,
        DATA_POLL, DATA_STAT, DATA_RD, DATA_WR,
        TX_POLL, TX_STAT, TX_WR, IRQ
    } state_t;
    typedef enum logic [1:0] {HDR_DATA = 2'b00, HDR_RELEASE = 2'b01} hdr_type_t;
    localparam logic [7:0] ACK_TAG = 8'hA5;
    localparam logic [2:0] CSR_STATUS = 3'd1;
    localparam int STAT_FULL_BIT = 0;
    localparam int STAT_EMPTY_BIT = 1;
endpackage

// File: rtl/hps_rx_slot_ctrl_slot_alloc.sv
// hps_rx_slot_ctrl_slot_alloc: slot occupancy register with lowest-free-index encoder
module hps_rx_slot_ctrl_slot_alloc #(
    parameter int SLOTS = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set,
    input  logic [2:0]       set_idx,
    input  logic             clr,
    input  logic [2:0]       clr_idx,
    output logic [SLOTS-1:0] busy,
    output logic             free_any,
    output logic [2:0]       free_idx
);
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--)
            if (!busy[i]) begin
                free_any = 1'b1;
                free_idx = 3'(i);
            end
    end

    // out-of-range release indices match no slot and are ignored
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            busy <= '0;
        else
            for (int i = 0; i < SLOTS; i++)
                if (set && set_idx == 3'(i))
                    busy[i] <= 1'b1;
                else if (clr && clr_idx == 3'(i))
                    busy[i] <= 1'b0;
endmodule

// File: rtl/hps_rx_slot_ctrl.sv
// hps_rx_slot_ctrl: drains HPS FIFO packets into SRAM slots, acks them and pulses rx_irq
module hps_rx_slot_ctrl
    import hps_rx_slot_pkg::*;
#(
    parameter int SLOTS      = 5,
    parameter int SLOT_WORDS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             rxf_read,
    input  logic [31:0]      rxf_readdata,
    output logic [2:0]       rxf_csr_address,
    output logic             rxf_csr_read,
    input  logic [31:0]      rxf_csr_readdata,
    output logic             txf_write,
    output logic [31:0]      txf_writedata,
    output logic [2:0]       txf_csr_address,
    output logic             txf_csr_read,
    input  logic [31:0]      txf_csr_readdata,
    output logic [7:0]       sram_address,
    output logic             sram_write,
    output logic [31:0]      sram_writedata,
    output logic             sram_chipselect,
    output logic             sram_clken,
    output logic [3:0]       sram_byteenable,
    output logic             rx_irq,
    output logic [SLOTS-1:0] slot_busy,
    output logic [7:0]       err_count
);
    localparam logic [6:0] MAX_LEN = 7'(SLOT_WORDS);

    state_t     state;
    logic [5:0] len, cnt;
    logic [2:0] slot, free_idx;
    logic       free_any;
    logic [1:0] hdr_type;
    logic [5:0] hdr_len;
    logic       hdr_ok;

    assign hdr_type        = rxf_readdata[31:30];
    assign hdr_len         = rxf_readdata[5:0];
    assign hdr_ok          = hdr_type == HDR_DATA && hdr_len != 6'd0 && {1'b0, hdr_len} <= MAX_LEN;
    assign rxf_csr_address = CSR_STATUS;
    assign txf_csr_address = CSR_STATUS;
    assign sram_clken      = 1'b1;
    assign sram_byteenable = 4'hF;
    assign sram_chipselect = sram_write;
    // FIFO data lands the same cycle the registered write strobe is high
    assign sram_writedata  = sram_write ? rxf_readdata : '0;

    hps_rx_slot_ctrl_slot_alloc #(.SLOTS(SLOTS)) u_alloc (
        .clk      (clk),
        .reset_n  (reset_n),
        .set      (state == TX_WR),
        .set_idx  (slot),
        .clr      (state == RX_WAIT && hdr_type == HDR_RELEASE),
        .clr_idx  (rxf_readdata[2:0]),
        .busy     (slot_busy),
        .free_any (free_any),
        .free_idx (free_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rxf_read      <= 1'b0;
            rxf_csr_read  <= 1'b0;
            txf_write     <= 1'b0;
            txf_writedata <= '0;
            txf_csr_read  <= 1'b0;
            sram_address  <= '0;
            sram_write    <= 1'b0;
            rx_irq        <= 1'b0;
            err_count     <= '0;
            len           <= '0;
            cnt           <= '0;
            slot          <= '0;
        end else begin
            rxf_read     <= 1'b0;
            rxf_csr_read <= 1'b0;
            txf_csr_read <= 1'b0;
            txf_write    <= 1'b0;
            sram_write   <= 1'b0;
            rx_irq       <= 1'b0;
            unique case (state)
                IDLE: begin
                    state        <= RX_POLL;
                    rxf_csr_read <= 1'b1;
                end
                RX_POLL: state <= RX_STAT;
                RX_STAT: begin
                    state        <= rxf_csr_readdata[STAT_EMPTY_BIT] ? RX_POLL : RX_RD;
                    rxf_csr_read <= rxf_csr_readdata[STAT_EMPTY_BIT];
                    rxf_read     <= !rxf_csr_readdata[STAT_EMPTY_BIT];
                end
                RX_RD: state <= RX_WAIT;
                RX_WAIT: begin
                    len <= hdr_len;
                    cnt <= '0;
                    if (hdr_ok && free_any) begin
                        slot         <= free_idx;
                        state        <= DATA_POLL;
                        rxf_csr_read <= 1'b1;
                    end else if (hdr_ok) begin
                        state <= WAIT_SLOT;
                    end else begin
                        state <= IDLE;
                        if (hdr_type != HDR_RELEASE && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end
                end
                WAIT_SLOT: if (free_any) begin
                    slot         <= free_idx;
                    state        <= DATA_POLL;
                    rxf_csr_read <= 1'b1;
                end
                DATA_POLL: state <= DATA_STAT;
                DATA_STAT: begin
                    state        <= rxf_csr_readdata[STAT_EMPTY_BIT] ? DATA_POLL : DATA_RD;
                    rxf_csr_read <= rxf_csr_readdata[STAT_EMPTY_BIT];
                    rxf_read     <= !rxf_csr_readdata[STAT_EMPTY_BIT];
                end
                DATA_RD: begin
                    state        <= DATA_WR;
                    sram_write   <= 1'b1;
                    sram_address <= 8'(int'(slot) * SLOT_WORDS + int'(cnt));
                    cnt          <= cnt + 6'd1;
                end
                DATA_WR: begin
                    state        <= cnt == len ? TX_POLL : DATA_POLL;
                    txf_csr_read <= cnt == len;
                    rxf_csr_read <= cnt != len;
                end
                TX_POLL: state <= TX_STAT;
                TX_STAT: begin
                    state         <= txf_csr_readdata[STAT_FULL_BIT] ? TX_POLL : TX_WR;
                    txf_csr_read  <= txf_csr_readdata[STAT_FULL_BIT];
                    txf_write     <= !txf_csr_readdata[STAT_FULL_BIT];
                    txf_writedata <= {ACK_TAG, 13'd0, slot, 2'd0, len};
                end
                TX_WR: begin
                    state  <= IRQ;
                    rx_irq <= 1'b1;
                end
                IRQ: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
